// File: rtl/playback_engine_pkg.sv
// rtl/playback_engine_pkg.sv - state, slot types and slot selection for playback_engine
package playback_engine_pkg;

  // Upper bound on SLOTS*CH*2; slot_sel takes the word zero-extended to this width.
  localparam int MAX_WORD_W = 4096;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_LOAD = 5'b00010,
    S_PLAY = 5'b00100,
    S_DONE = 5'b01000,
    S_ERR  = 5'b10000
  } pb_state_t;

  typedef struct packed {
    logic enable;
    logic out;
  } slot_t;

  function automatic slot_t slot_sel(input logic [MAX_WORD_W-1:0] word, input int slot,
                                     input int ch, input int chNum);
    return slot_t'(2'(word >> (2 * (slot * chNum + ch))));
  endfunction

endpackage

// File: rtl/playback_engine_oneshot.sv
// rtl/playback_engine_oneshot.sv - one-cycle pulse on each rising edge of an async strobe
module playback_engine_oneshot (
  input  logic clk,
  input  logic resetN,
  input  logic trigger,
  output logic pulse
);

  logic prev;

  // prev resets high so a strobe already high when reset releases does not fire.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      prev  <= trigger;
      pulse <= trigger & ~prev;
    end
  end

endmodule

// File: rtl/playback_engine.sv
// rtl/playback_engine.sv - serialises SLOTS slots per FIFO word onto CH channels, one slot per playbackClk edge
module playback_engine
  import playback_engine_pkg::*;
#(
  parameter int SLOTS = 16,
  parameter int CH    = 1,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    enable,
  input  logic                    abort,
  input  logic [SLOTS*CH*2-1:0]   fifoData,
  input  logic                    fifoValid,
  input  logic [CNT_W-1:0]        requestNum,
  input  logic                    playbackClk,
  output logic [CH-1:0]           dOut,
  output logic [CH-1:0]           dEnable,
  output logic                    advFIFO,
  output logic                    complete,
  output logic                    underrun,
  output logic                    busy,
  output logic [CNT_W-1:0]        wordCount
);

  localparam int WORD_W = SLOTS * CH * 2;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  pb_state_t          state;
  logic [WORD_W-1:0]  shadow;
  logic [SLOT_W-1:0]  slot;
  logic [CNT_W-1:0]   reqReg;
  logic               tick;
  logic               lastTick;
  logic               lastWord;
  logic               capture;
  slot_t              sel;

  playback_engine_oneshot uTick (
    .clk    (clk),
    .resetN (resetN),
    .trigger(playbackClk),
    .pulse  (tick)
  );

  assign lastTick = (state == S_PLAY) && tick && (slot == LAST_SLOT);
  assign lastWord = (wordCount + CNT_W'(1)) == reqReg;
  // A capture is the only source of advFIFO, so pop and shadow load can never diverge.
  assign capture  = !abort && fifoValid && ((state == S_LOAD) || (lastTick && !lastWord));
  assign advFIFO  = capture;

  assign complete = (state == S_DONE);
  assign underrun = (state == S_ERR);
  assign busy     = (state == S_LOAD) || (state == S_PLAY);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= S_IDLE;
      shadow    <= '0;
      slot      <= '0;
      reqReg    <= '0;
      wordCount <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      if (capture) begin
        shadow <= fifoData;
        slot   <= '0;
      end
      case (state)
        S_IDLE: begin
          if (enable) begin
            reqReg    <= requestNum;
            wordCount <= '0;
            state     <= (requestNum == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (fifoValid) state <= S_PLAY;
        end
        S_PLAY: begin
          if (tick) begin
            if (slot != LAST_SLOT) begin
              slot <= slot + SLOT_W'(1);
            end else begin
              wordCount <= wordCount + CNT_W'(1);
              if (lastWord)        state <= S_DONE;
              else if (!fifoValid) state <= S_ERR;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (!enable) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dOut    = '0;
    dEnable = '0;
    sel     = '0;
    if (state == S_PLAY && !abort) begin
      for (int c = 0; c < CH; c++) begin
        sel        = slot_sel(MAX_WORD_W'(shadow), int'(slot), c, CH);
        dOut[c]    = sel.out;
        dEnable[c] = sel.enable;
      end
    end
  end

endmodule

// File: tb/tb_playback_engine.sv
// tb/tb_playback_engine.sv - self-checking bench for playback_engine (16x1 and 8x4 instances)
module tb_playback_engine;

  typedef struct {
    bit dutB;
    int req;
    int avail;
    bit expComplete;
    bit expUnderrun;
    int expWc;
    int expAdv;
  } vec_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic enableA = 1'b0, enableB = 1'b0, abort = 1'b0, playbackClk = 1'b0;
  logic [15:0] requestNum = '0;

  logic [31:0] wordsA [8];
  logic [63:0] wordsB [8];
  int rdPtrA = 0, rdPtrB = 0, advCntA = 0, advCntB = 0, dblAdv = 0, availN = 0;
  logic prevAdvA = 1'b0, prevAdvB = 1'b0;

  logic [31:0] fifoDataA;
  logic [63:0] fifoDataB;
  logic validA, validB;
  logic [0:0] dOutA, dEnA;
  logic [3:0] dOutB, dEnB;
  logic advA, advB, completeA, completeB, underrunA, underrunB, busyA, busyB;
  logic [15:0] wcA, wcB;

  int errors = 0;
  int checks = 0;
  vec_t vecs [6];

  assign fifoDataA = wordsA[rdPtrA[2:0]];
  assign fifoDataB = wordsB[rdPtrB[2:0]];
  assign validA = rdPtrA < availN;
  assign validB = rdPtrB < availN;

  playback_engine #(.SLOTS(16), .CH(1), .CNT_W(16)) dutA (
    .clk(clk), .resetN(resetN), .enable(enableA), .abort(abort),
    .fifoData(fifoDataA), .fifoValid(validA), .requestNum(requestNum),
    .playbackClk(playbackClk), .dOut(dOutA), .dEnable(dEnA), .advFIFO(advA),
    .complete(completeA), .underrun(underrunA), .busy(busyA), .wordCount(wcA)
  );

  playback_engine #(.SLOTS(8), .CH(4), .CNT_W(16)) dutB (
    .clk(clk), .resetN(resetN), .enable(enableB), .abort(abort),
    .fifoData(fifoDataB), .fifoValid(validB), .requestNum(requestNum),
    .playbackClk(playbackClk), .dOut(dOutB), .dEnable(dEnB), .advFIFO(advB),
    .complete(completeB), .underrun(underrunB), .busy(busyB), .wordCount(wcB)
  );

  always #5 clk = ~clk;

  // FIFO model: each pop moves the read pointer; idle-and-disabled rewinds it for the next run.
  always @(posedge clk) begin
    if (!busyA && !enableA) begin
      rdPtrA  <= 0;
      advCntA <= 0;
    end else if (advA) begin
      rdPtrA  <= rdPtrA + 1;
      advCntA <= advCntA + 1;
    end
    if (!busyB && !enableB) begin
      rdPtrB  <= 0;
      advCntB <= 0;
    end else if (advB) begin
      rdPtrB  <= rdPtrB + 1;
      advCntB <= advCntB + 1;
    end
    if ((advA && prevAdvA) || (advB && prevAdvB)) dblAdv <= dblAdv + 1;
    prevAdvA <= advA;
    prevAdvB <= advB;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected {enable[3:0], out[3:0]} for slot s of the w-th word delivered.
  function automatic logic [7:0] modelSlot(input bit b, input int w, input int s);
    logic [7:0] r;
    logic [1:0] f;
    r = '0;
    if (b) begin
      for (int c = 0; c < 4; c++) begin
        f = 2'(wordsB[w] >> (2 * (s * 4 + c)));
        r[4 + c] = f[1];
        r[c]     = f[0];
      end
    end else begin
      f = 2'(wordsA[w] >> (2 * s));
      r[4] = f[1];
      r[0] = f[0];
    end
    return r;
  endfunction

  function automatic logic [7:0] obsSlot(input bit b);
    return b ? {dEnB, dOutB} : {3'b000, dEnA, 3'b000, dOutA};
  endfunction

  task automatic run(input vec_t v);
    int nSlots;
    int total;
    logic [7:0] expNext;
    nSlots = v.dutB ? 8 : 16;
    total  = v.expWc * nSlots;
    for (int i = 0; i < 8; i++) begin
      wordsA[i] = $urandom;
      wordsB[i] = {$urandom, $urandom};
    end
    availN = v.avail;
    requestNum = 16'(v.req);
    if (v.dutB) enableB = 1'b1; else enableA = 1'b1;
    @(negedge clk);
    chk("start_busy", v.dutB ? busyB : busyA, v.req != 0);
    chk("start_complete", v.dutB ? completeB : completeA, v.req == 0);
    chk("start_wordcount", v.dutB ? wcB : wcA, 0);
    chk("start_adv", v.dutB ? advB : advA, v.req != 0);
    requestNum = 16'($urandom);
    repeat (3) @(negedge clk);
    for (int k = 0; k < total; k++) begin
      chk("slot", obsSlot(v.dutB), modelSlot(v.dutB, k / nSlots, k % nSlots));
      playbackClk = 1'b1;
      @(negedge clk);
      chk("slot_hold", obsSlot(v.dutB), modelSlot(v.dutB, k / nSlots, k % nSlots));
      @(negedge clk);
      expNext = (k + 1 < total) ? modelSlot(v.dutB, (k + 1) / nSlots, (k + 1) % nSlots) : 8'h00;
      chk("slot_next", obsSlot(v.dutB), expNext);
      repeat (2) @(negedge clk);
      playbackClk = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("end_complete", v.dutB ? completeB : completeA, v.expComplete);
    chk("end_underrun", v.dutB ? underrunB : underrunA, v.expUnderrun);
    chk("end_wordcount", v.dutB ? wcB : wcA, v.expWc);
    chk("end_adv_count", v.dutB ? advCntB : advCntA, v.expAdv);
    chk("end_busy", v.dutB ? busyB : busyA, 0);
    chk("end_outputs", obsSlot(v.dutB), 0);
    chk("adv_back_to_back", dblAdv, 0);
    enableA = 1'b0;
    enableB = 1'b0;
    @(negedge clk);
    chk("rearm_complete", v.dutB ? completeB : completeA, 0);
    chk("rearm_underrun", v.dutB ? underrunB : underrunA, 0);
    chk("rearm_wc_hold", v.dutB ? wcB : wcA, v.expWc);
    @(negedge clk);
  endtask

  task automatic abortTest();
    for (int i = 0; i < 8; i++) wordsA[i] = $urandom;
    availN = 3;
    requestNum = 16'd3;
    enableA = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 21; k++) begin
      playbackClk = 1'b1;
      repeat (4) @(negedge clk);
      playbackClk = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("abort_pre_slot", obsSlot(1'b0), modelSlot(1'b0, 1, 5));
    playbackClk = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    enableA = 1'b0;
    #1;
    chk("abort_gate_en", dEnA, 0);
    chk("abort_gate_adv", advA, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busyA, 0);
    chk("abort_dEnable", dEnA, 0);
    chk("abort_wordcount", wcA, 1);
    chk("abort_adv_count", advCntA, 2);
    chk("abort_complete", completeA, 0);
    repeat (2) @(negedge clk);
    playbackClk = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_stays_idle", busyA, 0);
  endtask

  initial begin
    vec_t rv;
    for (int i = 0; i < 8; i++) begin
      wordsA[i] = '0;
      wordsB[i] = '0;
    end
    vecs[0] = '{dutB: 1'b0, req: 3, avail: 3, expComplete: 1'b1, expUnderrun: 1'b0, expWc: 3, expAdv: 3};
    vecs[1] = '{dutB: 1'b0, req: 0, avail: 3, expComplete: 1'b1, expUnderrun: 1'b0, expWc: 0, expAdv: 0};
    vecs[2] = '{dutB: 1'b0, req: 4, avail: 1, expComplete: 1'b0, expUnderrun: 1'b1, expWc: 1, expAdv: 1};
    vecs[3] = '{dutB: 1'b1, req: 2, avail: 2, expComplete: 1'b1, expUnderrun: 1'b0, expWc: 2, expAdv: 2};
    vecs[4] = '{dutB: 1'b1, req: 3, avail: 1, expComplete: 1'b0, expUnderrun: 1'b1, expWc: 1, expAdv: 1};
    vecs[5] = '{dutB: 1'b0, req: 2, avail: 5, expComplete: 1'b1, expUnderrun: 1'b0, expWc: 2, expAdv: 2};

    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    chk("reset_outputs_a", obsSlot(1'b0), 0);
    chk("reset_outputs_b", obsSlot(1'b1), 0);
    chk("reset_wordcount", {wcA, wcB}, 0);
    chk("reset_flags", {busyA, completeA, underrunA, advA, busyB, completeB, underrunB, advB}, 0);

    for (int i = 0; i < 6; i++) run(vecs[i]);
    abortTest();
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      rv.dutB  = 1'($urandom_range(0, 1));
      rv.req   = int'($urandom_range(1, 4));
      rv.avail = int'($urandom_range(1, 5));
      rv.expComplete = rv.avail >= rv.req;
      rv.expUnderrun = rv.avail < rv.req;
      rv.expWc  = (rv.avail < rv.req) ? rv.avail : rv.req;
      rv.expAdv = rv.expWc;
      run(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/playback_engine.md
# playback_engine

Parametrised playback engine for the channel unit: serialises SLOTS time-slots per memory word onto CH parallel output channels, one slot per rising edge of playbackClk, consuming exactly requestNum words from the upstream FIFO. Replaces the fixed 16-slot, single-channel player. Adds:
- full-word shadow buffering, so the FIFO advance point no longer depends on slot position
- underrun detection
- abort
- re-arming after completion

Sits between the pattern FIFO and the bus driver.

## Interface
Parameters:
- SLOTS, 16, slots per memory word (≥2)
- CH, 1, output channels per slot
- CNT_W, 16, width of requestNum and wordCount

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous, active-low reset
- enable  in  1  start request; level, sampled only in S_IDLE
- abort  in  1  synchronous stop; returns to S_IDLE
- fifoData  in  SLOTS*CH*2  word; slot s, channel c = {enable,out} at bits [2*(s*CH+c)+:2]
- fifoValid  in  1  fifoData holds a valid word
- requestNum  in  CNT_W  words to play; latched at start
- playbackClk  in  1  slot-advance strobe; only its rising edge acts
- dOut  out  CH  per-channel data
- dEnable  out  CH  per-channel driver enable
- advFIFO  out  1  one-cycle pop pulse, issued in the same cycle the word is captured
- complete  out  1  high in S_DONE
- underrun  out  1  high in S_ERR
- busy  out  1  high in S_LOAD and S_PLAY
- wordCount  out  CNT_W  words fully played in the current run

## Operation
- tick: one-cycle pulse from the rising edge of playbackClk, produced by oneshot.
- States: S_IDLE, S_LOAD, S_PLAY, S_DONE, S_ERR.
- **S_IDLE**:
  - Outputs disabled (dOut=0, dEnable=0).
  - On enable=1: latch requestNum into reqReg and clear wordCount.
  - If requestNum==0, go to S_DONE; otherwise go to S_LOAD.
- **S_LOAD**:
  - Wait for fifoValid.
  - When fifoValid: capture fifoData into shadow, pulse advFIFO, set slot=0, go to S_PLAY.
  - Ticks in S_LOAD are ignored.
- **S_PLAY**:
  - dOut[c]/dEnable[c] = shadow slot `slot`, channel c.
  - On tick with slot<SLOTS-1: slot++.
  - On tick with slot==SLOTS-1: wordCount++. Then:
    - if wordCount+1==reqReg, go to S_DONE;
    - else if fifoValid, capture the new word, pulse advFIFO, set slot=0 and stay in S_PLAY, with no gap cycle;
    - else go to S_ERR.
- **S_DONE**: complete=1, outputs disabled. Return to S_IDLE when enable=0, which re-arms the engine.
- **S_ERR**: underrun=1, outputs disabled. Return to S_IDLE when enable=0. wordCount holds its value for diagnosis.
- **abort=1** in any state: next state S_IDLE, outputs disabled, advFIFO=0. Abort takes priority over a tick and over fifoValid in the same cycle.
- Changes on requestNum after start are ignored.
- enable is ignored outside S_IDLE, S_DONE and S_ERR.

## Timing
- Reset: state S_IDLE, slot=0, wordCount=0, shadow=0. All outputs 0.
- A playbackClk rising edge at cycle n gives tick at n+1; the slot/output change is visible at n+2.
- Start: enable high at cycle n gives S_LOAD at n+1. With fifoValid high, advFIFO pulses at n+1 and slot 0 is driven from n+2.
- advFIFO is never high two consecutive cycles and is never high outside a capture.
- Word-boundary reload: the new slot 0 appears in the same cycle the last slot would otherwise have advanced.
- complete and underrun are registered state decodes, asserted the cycle after the deciding tick.
- A second playbackClk edge before the previous tick is consumed is lost. The playbackClk period must be ≥3 clk.
- wordCount wraps modulo 2^CNT_W but never exceeds reqReg.

## Structure
- dataTypes_pkg gains:
  - pb_state_t, the state enum (one-hot encoded via fsm_encoding);
  - slot_t, packed {enable,out} per channel;
  - function slot_sel(word, slot, ch).
- Sub-modules: reuse oneshot for tick. A shadow register plus mux is inline. One FSM and one slot counter of width $clog2(SLOTS).
- Target 200–300 lines.

## Test plan
- SLOTS=16, CH=1, requestNum=3, fifoValid always high, ticks every 8 clk → exactly 3 advFIFO pulses and 48 slot values matching the words in order, then complete=1 and wordCount=3.
- requestNum=0 with enable pulsed → S_DONE on the next cycle, advFIFO never asserted, complete=1.
- fifoValid drops before the 2nd word's boundary, requestNum=4 → underrun=1, outputs 0, wordCount=1, no extra advFIFO.
- abort asserted during slot 5 of word 2, coincident with a tick → S_IDLE, dEnable=0, no slot increment.
- CH=4, SLOTS=8 with distinct per-channel patterns → each channel's output matches its bit field.
- complete, then enable low, then enable high again → a second run replays requestNum words and wordCount restarts at 0.
